// File: rtl/aes128_key_store.sv
// aes128_key_store
// Sequential AES-128 key schedule. A cipher key is accepted over a
// valid/ready handshake, then one round key per cycle is expanded into an
// 11-entry register file. Any round key can be read back by index through a
// registered read port, in forward or reverse order.
//
// Optional feature macro: AES_KEY_STORE_IMC_EN
//   defined   -> rk_imc_out = InvMixColumns(rk_out), for the equivalent
//                inverse cipher
//   undefined -> rk_imc_out is tied to zero and no InvMixColumns logic exists
module aes128_key_store (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic [127:0] rk_imc_out,
    output logic         keys_valid,
    output logic         done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    localparam logic [3:0] LAST_RC   = 4'd10;
    localparam int         NUM_KEYS  = 11;

    // Forward AES S-box, used for the four SubWord lookups.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for rounds 1..10; other values never reach the datapath.
    function automatic logic [7:0] rcon_f(input logic [3:0] rc);
        logic [7:0] r;
        case (rc)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [1:0]   state_reg;
    logic [1:0]   state_next;
    logic [3:0]   rc_reg;
    logic [3:0]   rc_next;
    logic [127:0] work_reg;      // copy of the most recently written entry
    logic [127:0] work_next;
    logic         done_reg;
    logic [127:0] rk_out_reg;
    logic [127:0] rk_mem_reg [0:NUM_KEYS-1];

    logic         accept;
    logic         expanding;
    logic         last_step;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  w0_next;
    logic [31:0]  w1_next;
    logic [31:0]  w2_next;
    logic [31:0]  w3_next;
    logic [127:0] next_key;

    assign key_ready  = (state_reg != ST_EXPAND);
    assign keys_valid = (state_reg == ST_READY);
    assign done       = done_reg;
    assign rk_out     = rk_out_reg;

    assign accept     = key_valid && key_ready;
    assign expanding  = (state_reg == ST_EXPAND);
    assign last_step  = expanding && (rc_reg == LAST_RC);

    // Round-key step: the previous entry is always held in work_reg, so the
    // expansion never needs a read mux into the register file.
    assign rot_word = {work_reg[23:0], work_reg[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_word[8*gi +: 8] = SBOX[rot_word[8*gi +: 8]];
        end
    endgenerate

    assign w0_next  = work_reg[127:96] ^ sub_word ^ {rcon_f(rc_reg), 24'h0};
    assign w1_next  = work_reg[95:64] ^ w0_next;
    assign w2_next  = work_reg[63:32] ^ w1_next;
    assign w3_next  = work_reg[31:0]  ^ w2_next;
    assign next_key = {w0_next, w1_next, w2_next, w3_next};

    // Next-state logic: accept a key from IDLE/READY, count rounds in EXPAND.
    always_comb begin
        state_next = state_reg;
        rc_next    = rc_reg;
        work_next  = work_reg;
        case (state_reg)
            ST_IDLE, ST_READY: begin
                if (key_valid) begin
                    state_next = ST_EXPAND;
                    rc_next    = 4'd1;
                    work_next  = key;
                end
            end
            ST_EXPAND: begin
                work_next = next_key;
                if (rc_reg == LAST_RC) begin
                    state_next = ST_READY;
                end else begin
                    rc_next = rc_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control registers; done pulses on the edge that writes entry 10.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rc_reg    <= 4'd0;
            work_reg  <= 128'h0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rc_reg    <= rc_next;
            work_reg  <= work_next;
            done_reg  <= last_step;
        end
    end

    // Register file: entry 0 takes the cipher key, entry i takes round i.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_entry
            logic         wr_en;
            logic [127:0] wr_data;

            if (gi == 0) begin : g_key
                assign wr_en   = accept;
                assign wr_data = key;
            end else begin : g_round
                assign wr_en   = expanding && (rc_reg == 4'(gi));
                assign wr_data = next_key;
            end

            // Per-entry storage, cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rk_mem_reg[gi] <= 128'h0;
                end else if (wr_en) begin
                    rk_mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Registered read port; a same-edge write is not forwarded (old value).
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out_reg <= 128'h0;
        end else if (rk_idx <= LAST_RC) begin
            rk_out_reg <= rk_mem_reg[rk_idx];
        end else begin
            rk_out_reg <= 128'h0;
        end
    end

`ifdef AES_KEY_STORE_IMC_EN
    function automatic logic [7:0] xtime_f(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column: rows use coefficients 0e 0b 0d 09 rotated.
    function automatic logic [31:0] inv_mix_col_f(input logic [31:0] col);
        logic [7:0] a   [0:3];
        logic [7:0] m9  [0:3];
        logic [7:0] m11 [0:3];
        logic [7:0] m13 [0:3];
        logic [7:0] m14 [0:3];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int j = 0; j < 4; j++) begin
            a[j]   = col[31-8*j -: 8];
            x2     = xtime_f(a[j]);
            x4     = xtime_f(x2);
            x8     = xtime_f(x4);
            m9[j]  = x8 ^ a[j];
            m11[j] = x8 ^ x2 ^ a[j];
            m13[j] = x8 ^ x4 ^ a[j];
            m14[j] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_imc
            assign rk_imc_out[127-32*gi -: 32] = inv_mix_col_f(rk_out_reg[127-32*gi -: 32]);
        end
    endgenerate
`else
    assign rk_imc_out = 128'h0;
`endif

endmodule

// File: tb/tb_aes128_key_store.sv
// Directed bench for aes128_key_store: FIPS-197 schedules, read port,
// handshake during expansion, reset mid-expansion and the optional
// InvMixColumns output (AES_KEY_STORE_IMC_EN).
module tb_aes128_key_store;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic [127:0] rk_imc_out;
    logic         keys_valid;
    logic         done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [127:0] gold_a [0:10];
    logic [127:0] gold_b [0:10];

    aes128_key_store dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_imc_out (rk_imc_out),
        .keys_valid (keys_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Steps until done is seen; returns edges taken (30 means timed out).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 30) begin
            step();
            cycles++;
        end
    endtask

    // Bench-side GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] imc_model(input logic [127:0] v);
        logic [7:0]   coef [0:3];
        logic [7:0]   a    [0:3];
        logic [7:0]   acc;
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = v[127-32*c-8*j -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - r + 4) % 4]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    initial begin
        int cyc;
        logic [127:0] exp_imc;

        gold_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        gold_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        gold_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        gold_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        gold_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        gold_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        gold_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        gold_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        gold_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        gold_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        gold_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        gold_b[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        gold_b[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        gold_b[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        gold_b[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        gold_b[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        gold_b[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        gold_b[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        gold_b[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        gold_b[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        gold_b[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        gold_b[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        // Reset
        rst = 1'b1; key = 128'h0; key_valid = 1'b0; rk_idx = 4'd0;
        step(); step(); step();
        rst = 1'b0;
        chk1("reset_key_ready", key_ready, 1'b1);
        chk1("reset_keys_valid", keys_valid, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk("reset_rk_out", rk_out, 128'h0);
        chk("reset_rk_imc_out", rk_imc_out, 128'h0);

        // FIPS-197 key A
        key = gold_a[0]; key_valid = 1'b1;
        step();
        $display("tx: key A accepted");
        key_valid = 1'b0;
        chk1("a_expand_key_ready", key_ready, 1'b0);
        chk1("a_expand_keys_valid", keys_valid, 1'b0);
        wait_done(cyc);
        chk("a_done_latency", 128'(cyc), 128'd10);
        chk1("a_keys_valid", keys_valid, 1'b1);
        chk1("a_key_ready", key_ready, 1'b1);
        step();
        chk1("a_done_pulse_end", done, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            rk_idx = 4'(i);
            step();
            $display("tx: read A idx %0d -> %h", i, rk_out);
            chk($sformatf("a_rk%0d", i), rk_out, gold_a[i]);
        end
        rk_idx = 4'd9;
        step();
`ifdef AES_KEY_STORE_IMC_EN
        exp_imc = imc_model(gold_a[9]);
`else
        exp_imc = 128'h0;
`endif
        chk("a_imc_rk9", rk_imc_out, exp_imc);

        // Key B, reverse sweep
        key = gold_b[0]; key_valid = 1'b1;
        step();
        $display("tx: key B accepted");
        key_valid = 1'b0;
        chk1("b_keys_valid_drop", keys_valid, 1'b0);
        wait_done(cyc);
        chk("b_done_latency", 128'(cyc), 128'd10);
        for (int i = 10; i >= 0; i--) begin
            rk_idx = 4'(i);
            step();
            $display("tx: read B idx %0d -> %h", i, rk_out);
            chk($sformatf("b_rk%0d", i), rk_out, gold_b[i]);
        end
        for (int i = 11; i <= 15; i++) begin
            rk_idx = 4'(i);
            step();
            chk($sformatf("b_oob_idx%0d", i), rk_out, 128'h0);
        end

        // Handshake: second key held during expansion
        key = gold_a[0]; key_valid = 1'b1;
        step();
        $display("tx: key A accepted, key B held");
        key = gold_b[0];
        rk_idx = 4'd0;
        cyc = 0;
        while (key_ready !== 1'b1 && cyc < 30) begin
            cyc++;
            step();
        end
        chk("hs_ready_low_cycles", 128'(cyc), 128'd10);
        chk1("hs_keys_valid_before", keys_valid, 1'b1);
        step();
        $display("tx: key B accepted after ready");
        key_valid = 1'b0;
        chk("hs_entry0_old_value", rk_out, gold_a[0]);
        chk1("hs_keys_valid_drop", keys_valid, 1'b0);
        chk1("hs_key_ready_low", key_ready, 1'b0);
        cyc = 0;
        while (keys_valid !== 1'b1 && cyc < 30) begin
            step();
            cyc++;
        end
        chk("hs_keys_valid_return", 128'(cyc), 128'd10);
        rk_idx = 4'd10;
        step();
        chk("hs_rk10", rk_out, gold_b[10]);
        rk_idx = 4'd0;
        step();
        chk("hs_rk0", rk_out, gold_b[0]);

        // Reset while rc = 5
        key = gold_a[0]; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("tx: reset mid-expansion");
        chk1("mid_rst_key_ready", key_ready, 1'b1);
        chk1("mid_rst_keys_valid", keys_valid, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk("mid_rst_rk_out", rk_out, 128'h0);
        for (int i = 0; i <= 15; i++) begin
            rk_idx = 4'(i);
            step();
            chk($sformatf("mid_rst_clear_idx%0d", i), rk_out, 128'h0);
        end
        key = gold_b[0]; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        wait_done(cyc);
        chk("post_rst_done_latency", 128'(cyc), 128'd10);
        rk_idx = 4'd10;
        step();
        chk("post_rst_rk10", rk_out, gold_b[10]);
        rk_idx = 4'd5;
        step();
        chk("post_rst_rk5", rk_out, gold_b[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
